// File: rtl/cache_axi_line_engine_if.sv
// AXI4-Lite master bus between the line engine and the memory fabric.
// Single-beat channels only; the engine is the master side.
interface cache_axi_line_engine_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/cache_axi_line_engine.sv
// Line evict/refill engine: one cache line as WORDS_PER_LINE serial AXI4-Lite beats, one outstanding.
// Latency: per beat >= 2 cycles (addr/data + resp), plus one DONE cycle; cmd_ready only in IDLE.
// Backpressure: each channel waits on its ready/valid; optional CACHE_LINE_ENG_CRIT_WORD_EN gives critical-word-first order.
module cache_axi_line_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_BYTES = 16,
    localparam int WORD_BYTES     = DATA_WIDTH / 8,
    localparam int WORDS_PER_LINE = LINE_BYTES / WORD_BYTES,
    localparam int OFFSET_BITS    = $clog2(LINE_BYTES),
    localparam int LINE_BITS      = LINE_BYTES * 8,
    localparam int IDX_W          = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1,
    localparam int WB_BITS        = $clog2(WORD_BYTES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_is_evict,
    input  logic [ADDR_WIDTH-1:0]  cmd_line_addr,
    input  logic [LINE_BITS-1:0]   cmd_wline,
    input  logic [IDX_W-1:0]       cmd_word_off,
    output logic                   done_valid,
    output logic                   done_is_evict,
    output logic [1:0]             done_resp,
    output logic [LINE_BITS-1:0]   rline,
`ifdef CACHE_LINE_ENG_CRIT_WORD_EN
    output logic                   crit_valid,
`endif
    cache_axi_line_engine_if.master m
);
    typedef enum logic [2:0] {IDLE, W_ADDR, W_RESP, R_ADDR, R_DATA, DONE} state_t;

    state_t                            state_q, state_d;
    logic [ADDR_WIDTH-OFFSET_BITS-1:0] tag_q;
    logic [LINE_BITS-1:0]              wline_q;
    logic [LINE_BITS-1:0]              rline_q;
    logic                              is_evict_q;
    logic [IDX_W-1:0]                  beat_q;
    logic [IDX_W-1:0]                  start_q;
    logic [1:0]                        resp_q;
    logic                              aw_done_q;
    logic                              w_done_q;

    logic [IDX_W-1:0]       word_idx;
    logic [OFFSET_BITS-1:0] beat_off;
    logic [ADDR_WIDTH-1:0]  beat_addr;
    logic                   last_beat;
    logic                   aw_hs;
    logic                   w_hs;
    logic                   unused_bits;

    // Line offset bits are recomputed per beat, so the caller's low bits never reach the bus.
    assign unused_bits = ^{cmd_word_off, cmd_line_addr[OFFSET_BITS-1:0]};

    assign word_idx  = (start_q + beat_q) & IDX_W'(WORDS_PER_LINE - 1);
    assign beat_off  = OFFSET_BITS'(word_idx) << WB_BITS;
    assign beat_addr = {tag_q, beat_off};
    assign last_beat = (beat_q == IDX_W'(WORDS_PER_LINE - 1));

    assign m.awvalid = (state_q == W_ADDR) && !aw_done_q;
    assign m.awaddr  = beat_addr;
    assign m.awprot  = 3'b000;
    assign m.wvalid  = (state_q == W_ADDR) && !w_done_q;
    assign m.wdata   = wline_q[word_idx*DATA_WIDTH +: DATA_WIDTH];
    assign m.wstrb   = '1;
    assign m.bready  = (state_q == W_RESP);
    assign m.arvalid = (state_q == R_ADDR);
    assign m.araddr  = beat_addr;
    assign m.arprot  = 3'b000;
    assign m.rready  = (state_q == R_DATA);

    assign aw_hs = m.awvalid && m.awready;
    assign w_hs  = m.wvalid && m.wready;

    assign cmd_ready     = (state_q == IDLE);
    assign done_valid    = (state_q == DONE);
    assign done_is_evict = is_evict_q;
    assign done_resp     = resp_q;
    assign rline         = rline_q;

`ifdef CACHE_LINE_ENG_CRIT_WORD_EN
    assign crit_valid = (state_q == R_DATA) && m.rvalid && (beat_q == '0);
`endif

    function automatic logic [1:0] merge_resp(input logic [1:0] cur, input logic [1:0] nxt);
        return (cur == 2'b00) ? nxt : cur;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (cmd_valid) state_d = cmd_is_evict ? W_ADDR : R_ADDR;
            W_ADDR: if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = W_RESP;
            W_RESP: if (m.bvalid) state_d = last_beat ? DONE : W_ADDR;
            R_ADDR: if (m.arready) state_d = R_DATA;
            R_DATA: if (m.rvalid) state_d = last_beat ? DONE : R_ADDR;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q      <= '0;
            wline_q    <= '0;
            rline_q    <= '0;
            is_evict_q <= 1'b0;
            beat_q     <= '0;
            start_q    <= '0;
            resp_q     <= 2'b00;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        tag_q      <= cmd_line_addr[ADDR_WIDTH-1:OFFSET_BITS];
                        wline_q    <= cmd_wline;
                        is_evict_q <= cmd_is_evict;
                        beat_q     <= '0;
                        resp_q     <= 2'b00;
                        aw_done_q  <= 1'b0;
                        w_done_q   <= 1'b0;
`ifdef CACHE_LINE_ENG_CRIT_WORD_EN
                        start_q    <= cmd_word_off;
`else
                        start_q    <= '0;
`endif
                    end
                end
                W_ADDR: begin
                    if (aw_hs) aw_done_q <= 1'b1;
                    if (w_hs)  w_done_q  <= 1'b1;
                end
                W_RESP: begin
                    // Both halves are rearmed for the next beat's address/data pair.
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    if (m.bvalid) begin
                        resp_q <= merge_resp(resp_q, m.bresp);
                        if (!last_beat) beat_q <= beat_q + 1'b1;
                    end
                end
                R_DATA: begin
                    if (m.rvalid) begin
                        rline_q[word_idx*DATA_WIDTH +: DATA_WIDTH] <= m.rdata;
                        resp_q <= merge_resp(resp_q, m.rresp);
                        if (!last_beat) beat_q <= beat_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/cache_axi_line_engine.md
Name: cache_axi_line_engine

Overview:
- Memory-side stage directly downstream of the cache controller FSM.
- Accepts one line command at a time: evict (write back a dirty line) or refill (fetch a line).
- AXI4-Lite has no bursts, so each command becomes WORDS_PER_LINE single-beat AXI4-Lite master transactions, issued strictly one at a time.
- Returns a one-cycle completion pulse with the assembled refill line and a merged response code.

Parameters:
- ADDR_WIDTH, 32, AXI/core address width.
- DATA_WIDTH, 32, AXI data width; must be 32 or 64.
- LINE_BYTES, 16, bytes per cache line; a power of 2, at least DATA_WIDTH/8.
- Derived, not overridable: WORD_BYTES=DATA_WIDTH/8, WORDS_PER_LINE=LINE_BYTES/WORD_BYTES, OFFSET_BITS=$clog2(LINE_BYTES), LINE_BITS=LINE_BYTES*8.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_is_evict  in  1  1=write line to memory, 0=read line from memory.
- cmd_line_addr  in  ADDR_WIDTH  line address; low OFFSET_BITS ignored.
- cmd_wline  in  LINE_BITS  evict data; word i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- cmd_word_off  in  max(1,$clog2(WORDS_PER_LINE))  critical word index (used only with the optional feature).
- done_valid  out  1  one-cycle completion pulse.
- done_is_evict  out  1  echo of the latched cmd_is_evict.
- done_resp  out  2  merged AXI response.
- rline  out  LINE_BITS  refilled line; stable from done_valid until the next accepted command.
- m_awvalid/m_awready/m_awaddr[ADDR_WIDTH]/m_awprot[3]  AXI4-Lite write address channel.
- m_wvalid/m_wready/m_wdata[DATA_WIDTH]/m_wstrb[DATA_WIDTH/8]  AXI4-Lite write data channel.
- m_bvalid/m_bready/m_bresp[2]  AXI4-Lite write response channel.
- m_arvalid/m_arready/m_araddr[ADDR_WIDTH]/m_arprot[3]  AXI4-Lite read address channel.
- m_rvalid/m_rready/m_rdata[DATA_WIDTH]/m_rresp[2]  AXI4-Lite read data channel.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all m_*valid=0; m_bready=0; m_rready=0; done_valid=0; done_resp=2'b00; done_is_evict=0; rline=0; beat counter=0; sticky response=OKAY. Any in-flight command is dropped with no completion.
- States: IDLE, W_ADDR, W_RESP, R_ADDR, R_DATA, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch address, line data and direction; clear beat counter and sticky response; go to W_ADDR (evict) or R_ADDR (refill).
- Word index = (start + beat) mod WORDS_PER_LINE, with start=0. Wrap is natural truncation.
- Beat address = {line_addr[ADDR_WIDTH-1:OFFSET_BITS], word_idx, log2(WORD_BYTES) zeros}.
- m_awprot = m_arprot = 3'b000; m_wstrb = all ones.
- W_ADDR:
  - On entry, assert m_awvalid and m_wvalid in the same cycle.
  - Each valid drops independently on its own handshake; address and data stay stable while valid.
  - When both channels have handshaken (same or different cycles), go to W_RESP.
- W_RESP: m_bready=1. On m_bvalid, merge m_bresp; if last beat go to DONE, else increment the beat counter and return to W_ADDR.
- R_ADDR: m_arvalid=1 until m_arready, then go to R_DATA.
- R_DATA: m_rready=1. On m_rvalid, write m_rdata into rline word word_idx and merge m_rresp; if last beat go to DONE, else increment and return to R_ADDR.
- Merge rule: the first non-OKAY response is sticky. All remaining beats still execute; a transaction is never aborted.
- DONE: done_valid=1 for exactly one cycle, then IDLE. Back-to-back commands therefore leave at least one idle cycle between them (cmd_ready low in DONE).
- Only one AXI transaction is outstanding at any time. No valid depends combinationally on a ready.
- An evict never drives the read channels; a refill never drives the write channels.

Optional Feature:
- Macro: CACHE_LINE_ENG_CRIT_WORD_EN.
- Defined: start=cmd_word_off, latched at command accept, so beats wrap modulo WORDS_PER_LINE (e.g. offset 2 of 4 gives order 2,3,0,1). Applies to evict and refill. Adds output crit_valid (1 bit), pulsed on the cycle the start word's R handshake completes during a refill. rline[start word] is valid from that cycle onward.
- Undefined: start=0; cmd_word_off is ignored; crit_valid port is absent.

Test Plan:
- Refill, line_addr=0x0000_1234, slave OKAY, 1-cycle ready latency -> araddr sequence 0x1230,0x1234,0x1238,0x123C; rline assembled in word order; done_valid for 1 cycle with done_resp=00 and done_is_evict=0.
- Evict, line_addr=0x80, cmd_wline={D,C,B,A}, AWREADY 3 cycles ahead of WREADY -> beats (0x80,A),(0x84,B),(0x88,C),(0x8C,D); each valid held until its own handshake; done_resp=00.
- Refill where beat 1 returns SLVERR and beat 3 returns DECERR -> all 4 beats still issued; done_resp=10.
- Reset asserted during W_RESP of beat 2 -> all outputs at reset values immediately; no done_valid; next command starts at beat 0.
- Two consecutive commands with cmd_valid held high -> the second is accepted only after the done_valid cycle; no overlap of AXI transactions.
- With CACHE_LINE_ENG_CRIT_WORD_EN defined, refill at 0x40 with cmd_word_off=3 -> araddr order 0x4C,0x40,0x44,0x48; crit_valid on the first R handshake; rline correct at done_valid.
